// File: rtl/seq_muldiv_if.sv
// Start/busy/done handshake bundle for the iterative multiplier/divider.
interface seq_muldiv_if #(
  parameter int N = 4
);
  logic           start;
  logic           op;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] Y;
  logic           dbz;

  modport master (
    output start, op, A, B,
    input  busy, done, Y, dbz
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, Y, dbz
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative N-bit unsigned multiplier (shift-add) / restoring divider.
// One step per clock; N steps per operation; result is 2N bits wide.
// Both operations share one {hi, lo} shift register: for multiply hi
// accumulates the partial product while lo shifts out the multiplier;
// for divide hi is the (N+1)-bit partial remainder and lo shifts the
// dividend out while quotient bits shift in.
module seq_muldiv #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N+1)
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic           op_reg;
  logic [N-1:0]   opnd_reg;   // multiplicand (op=0) or divisor (op=1)
  logic [N:0]     hi_reg;
  logic [N-1:0]   lo_reg;
  logic [2*N-1:0] y_reg;
  logic           dbz_reg;

  logic           accept;
  logic           last;
  logic           busy;
  logic           done;
  logic [N:0]     sum;
  logic [2*N:0]   prod_shift;
  logic [N:0]     shifted;
  logic           ge;
  logic [N:0]     hi_step;
  logic [N-1:0]   lo_step;

  // Start is only honoured when not iterating; DONE accepts like IDLE.
  assign accept = ((state_reg == IDLE) || (state_reg == DONE)) && bus.start;
  assign last   = (state_reg == RUN) && (count_reg == CW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.Y    = y_reg;
  assign bus.dbz  = dbz_reg;

  // One multiply or divide step computed from the current registers.
  always_comb begin
    sum        = lo_reg[0] ? (hi_reg + {1'b0, opnd_reg}) : hi_reg;
    prod_shift = {sum, lo_reg} >> 1;
    shifted    = {hi_reg[N-1:0], lo_reg[N-1]};
    ge         = (shifted >= {1'b0, opnd_reg});
    if (op_reg) begin
      // A zero divisor always "fits", giving all-ones quotient and rem = A.
      hi_step = ge ? (shifted - {1'b0, opnd_reg}) : shifted;
      lo_step = {lo_reg[N-2:0], ge};
    end else begin
      hi_step = prod_shift[2*N:N];
      lo_step = prod_shift[N-1:0];
    end
  end

  // Operand latch, iteration datapath, saturating counter and result hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      op_reg    <= 1'b0;
      opnd_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      y_reg     <= '0;
      dbz_reg   <= 1'b0;
    end else if (accept) begin
      op_reg    <= bus.op;
      opnd_reg  <= bus.op ? bus.B : bus.A;
      lo_reg    <= bus.op ? bus.A : bus.B;
      hi_reg    <= '0;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      hi_reg <= hi_step;
      lo_reg <= lo_step;
      if (count_reg != CW'(N)) count_reg <= count_reg + CW'(1);
      if (last) begin
        y_reg   <= {hi_step[N-1:0], lo_step};
        dbz_reg <= op_reg && (opnd_reg == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv at N=4 and N=8.
module tb_seq_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  seq_muldiv_if #(.N(4)) bus4 ();
  seq_muldiv_if #(.N(8)) bus8 ();

  seq_muldiv #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  seq_muldiv #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic [15:0] y;
    logic        dbz;
    int          k;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4, e8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on the architectural rules.
  function automatic logic [16:0] model(int unsigned a, int unsigned b, bit o, int w);
    int unsigned y;
    bit z;
    z = 1'b0;
    if (!o)          y = a * b;
    else if (b == 0) begin y = (a << w) | ((32'd1 << w) - 1); z = 1'b1; end
    else             y = ((a % b) << w) | (a / b);
    return {z, y[15:0]};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor for the N=4 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus4.done === 1'b1) begin
      if (sb4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done4: got done=1 expected no pending op (Y=%0h)", bus4.Y);
      end else begin
        e4 = sb4.pop_front();
        check("y4", {24'b0, bus4.Y}, {16'b0, e4.y});
        check("dbz4", {31'b0, bus4.dbz}, {31'b0, e4.dbz});
        check("latency4", cyc - e4.k, 4);
        $display("txn n=4 y=%0h dbz=%0b lat=%0d", bus4.Y, bus4.dbz, cyc - e4.k);
      end
    end
  end

  // Monitor for the N=8 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus8.done === 1'b1) begin
      if (sb8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done8: got done=1 expected no pending op (Y=%0h)", bus8.Y);
      end else begin
        e8 = sb8.pop_front();
        check("y8", {16'b0, bus8.Y}, {16'b0, e8.y});
        check("dbz8", {31'b0, bus8.dbz}, {31'b0, e8.dbz});
        check("latency8", cyc - e8.k, 8);
        $display("txn n=8 y=%0h dbz=%0b lat=%0d", bus8.Y, bus8.dbz, cyc - e8.k);
      end
    end
  end

  // Drives one request; called just after a rising edge with the DUT able to accept.
  task automatic issue(int w, int unsigned a, int unsigned b, bit o);
    exp_t e;
    logic [16:0] m;
    m = model(a, b, o, w);
    if (w == 4) begin
      bus4.start = 1'b1; bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.op = o;
    end else begin
      bus8.start = 1'b1; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.op = o;
    end
    @(posedge clk); #1;
    e.y   = m[15:0];
    e.dbz = m[16];
    e.k   = cyc;
    if (w == 4) begin sb4.push_back(e); bus4.start = 1'b0; end
    else        begin sb8.push_back(e); bus8.start = 1'b0; end
  endtask

  task automatic wait_done(int w);
    int pending;
    pending = (w == 4) ? sb4.size() : sb8.size();
    for (int i = 0; i < 40 && pending != 0; i++) begin
      @(posedge clk); #1;
      pending = (w == 4) ? sb4.size() : sb8.size();
    end
    if (pending != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout%0d: got %0d pending results expected 0", w, pending);
      if (w == 4) sb4.delete(); else sb8.delete();
    end
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int unsigned a, b;
    bit o;
    exp_t e;
    logic [16:0] m;

    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.op = 1'b0; bus4.A = '0; bus4.B = '0;
    bus8.start = 1'b0; bus8.op = 1'b0; bus8.A = '0; bus8.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy4", {31'b0, bus4.busy}, 0);
    check("rst_done4", {31'b0, bus4.done}, 0);
    check("rst_y4",    {24'b0, bus4.Y}, 0);
    check("rst_dbz4",  {31'b0, bus4.dbz}, 0);
    check("rst_busy8", {31'b0, bus8.busy}, 0);
    check("rst_y8",    {16'b0, bus8.Y}, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed multiplies and divides.
    issue(4, 15, 15, 0); wait_done(4);
    issue(4, 12, 7, 0);  wait_done(4);
    issue(4, 0, 0, 0);   wait_done(4);
    issue(4, 13, 4, 1);  wait_done(4);
    issue(4, 3, 9, 1);   wait_done(4);
    issue(4, 9, 0, 1);   wait_done(4);
    issue(4, 2, 3, 0);   wait_done(4);
    issue(4, 15, 15, 1); wait_done(4);

    // Start pulsed with different operands mid-run must be ignored.
    issue(4, 5, 5, 0);
    idle_cycles(1);
    bus4.A = 4'd9; bus4.B = 4'd3; bus4.op = 1'b1; bus4.start = 1'b1;
    idle_cycles(2);
    bus4.start = 1'b0;
    wait_done(4);
    idle_cycles(12);

    // Reset mid-operation abandons it: outputs clear and no done follows.
    issue(4, 15, 15, 0);
    idle_cycles(1);
    rst_n = 1'b0;
    sb4.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", {31'b0, bus4.busy}, 0);
    check("midrst_done", {31'b0, bus4.done}, 0);
    check("midrst_y",    {24'b0, bus4.Y}, 0);
    check("midrst_dbz",  {31'b0, bus4.dbz}, 0);
    idle_cycles(8);
    issue(4, 2, 2, 0); wait_done(4);

    // Start held high: second request accepted on the DONE cycle.
    m = model(3, 4, 0, 4);
    bus4.A = 4'd3; bus4.B = 4'd4; bus4.op = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    e.y = m[15:0]; e.dbz = m[16]; e.k = cyc; sb4.push_back(e);
    bus4.A = 4'd6; bus4.B = 4'd7;
    idle_cycles(4 + 1);
    m = model(6, 7, 0, 4);
    e.y = m[15:0]; e.dbz = m[16]; e.k = cyc; sb4.push_back(e);
    bus4.start = 1'b0;
    wait_done(4);

    // Randomized N=4 operations.
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
      o = 1'($urandom_range(0, 1));
      issue(4, a, b, o);
      wait_done(4);
    end

    // N=8 regression.
    issue(8, 255, 255, 0); wait_done(8);
    issue(8, 200, 7, 1);   wait_done(8);
    issue(8, 77, 0, 1);    wait_done(8);
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
      o = 1'($urandom_range(0, 1));
      issue(8, a, b, o);
      wait_done(8);
    end

    idle_cycles(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Parametrised, iterative N-bit unsigned multiplier/divider; next generation of the combinational `mul` block.
- One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
- Start/busy/done handshake, so it sits on a datapath beside a controlling FSM and trades latency for area.
- Result width is 2N, matching the existing multiplier product convention.

Parameters:
- N, 4, operand width in bits (N >= 2).
- CW, $clog2(N+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  request; sampled only when the block can accept.
- op  input  1  operation: 0 = multiply, 1 = divide; latched with the operands.
- A  input  N  multiplicand or dividend, unsigned.
- B  input  N  multiplier or divisor, unsigned.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when Y is updated.
- Y  output  2N  result:
  - op=0: the product A*B.
  - op=1: {remainder, quotient}, with the remainder in Y[2N-1:N] and the quotient in Y[N-1:0].
- dbz  output  1  divide-by-zero flag for the last result.

Behaviour:
- Reset:
  - Synchronous on any edge with rst_n=0: state=IDLE, busy=0, done=0, Y=0, dbz=0, internal registers cleared.
  - Reset takes priority over every other event, including an operation in progress. That operation is abandoned and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k latches A, B and op, clears the accumulator, sets count=0, moves to RUN and raises busy. With start=0 the FSM stays in IDLE.
  - RUN: one iteration per edge for exactly N edges (k+1 .. k+N). At edge k+N it writes Y and dbz, drops busy, raises done and moves to DONE. Latency from the accepting edge to done high is N cycles.
  - DONE: lasts one cycle with done=1 and busy=0. start=1 here is accepted exactly as in IDLE, so back-to-back operations have no dead cycle. Otherwise the FSM returns to IDLE and done drops.
- Handshake rules:
  - start is ignored while busy=1. No queuing, and no effect on the result.
  - A, B and op may change freely after acceptance; only the latched copies are used.
- Output hold: Y and dbz hold their value from the last completion until the next completion or reset. They do not change at acceptance.
- Multiply: unsigned shift-add over N steps. Product is exact in 2N bits, so no overflow is possible.
- Divide: restoring division, with an (N+1)-bit partial remainder to absorb the borrow.
  - Quotient = floor(A/B), remainder = A mod B.
- Divide by zero (B=0):
  - Takes the same N-cycle latency and the normal algorithm runs unchanged.
  - Result is quotient = all ones and remainder = A.
  - dbz=1 with done. dbz=0 for every multiply and every divide with B≠0.
- Boundaries:
  - A=0 or B=0 in multiply gives Y=0.
  - A<B in divide gives quotient 0 and remainder A.
  - Maximum operands are exact: (2^N-1)^2 for multiply; quotient 1, remainder 0 for A=B=2^N-1.
- Counter: the counter never wraps. It saturates at N and is cleared on acceptance.

Test Plan:
- N=4, op=0: A=15, B=15 → done exactly 4 cycles after the accepting edge, Y=8'd225, dbz=0. Then A=12, B=7 → Y=8'd84. Then A=0, B=0 → Y=0.
- N=4, op=1: A=13, B=4 → Y=8'h13 (remainder 1, quotient 3), dbz=0. Then A=3, B=9 → Y=8'h30.
- N=4, op=1: A=9, B=0 → Y={4'd9,4'hF}, dbz=1 with done after 4 cycles. The next multiply 2x3 → Y=6, dbz=0.
- Assert start with A=5, B=5, op=0, then change A/B/op and pulse start again mid-RUN → single done, Y=25, no second operation started.
- Start 15x15, drive rst_n=0 for one edge two cycles in → busy=0, Y=0, done never pulses. A new start 2x2 then completes with Y=4.
- Hold start=1 continuously with 3x4 then 6x7 → done pulses on consecutive DONE cycles N+1 apart, Y=12 then Y=42. N=8 regression: 255x255=65025, 200/7 → quotient 28, remainder 4.
